// File: rtl/c3lib_fifo_pkg.sv
// c3lib_fifo_pkg
// Shared definitions for the c3lib single-clock FIFO:
//   - read-mode selectors for the RD_MODE parameter
//   - fifo_depth(): entry count implied by an address width
package c3lib_fifo_pkg;

  localparam int FIFO_RD_SHOWAHEAD = 0;
  localparam int FIFO_RD_REG       = 1;

  function automatic int fifo_depth(input int awidth);
    return 1 << awidth;
  endfunction

endpackage

// File: rtl/c3lib_fifo_mem.sv
// c3lib_fifo_mem
// DEPTH x DWIDTH storage array, cleared to zero by reset.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   we_i           write enable
//   waddr_i        write address
//   wdata_i        write data
//   raddr_i        read address
//   rdata_o        combinational read data (mem[raddr_i])
module c3lib_fifo_mem
  import c3lib_fifo_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [AWIDTH-1:0] waddr_i,
  input  logic [DWIDTH-1:0] wdata_i,
  input  logic [AWIDTH-1:0] raddr_i,
  output logic [DWIDTH-1:0] rdata_o
);

  localparam int DEPTH = fifo_depth(AWIDTH);

  logic [DWIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/c3lib_sync_fifo.sv
// c3lib_sync_fifo
// Single-clock FIFO with full-range occupancy count, programmable partial
// thresholds, show-ahead or registered read, synchronous flush and sticky
// overflow/underflow flags.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   clr                synchronous flush (highest priority)
//   wr_en, wr_data     write request and data
//   rd_en              read request
//   rd_data, rd_valid  read data; rd_valid = ~empty (show-ahead) or
//                      "rd_data updated this cycle" (registered)
//   r_pempty, r_pfull  static partial-empty / partial-full thresholds
//   numdata            occupancy 0..DEPTH
//   empty, pempty      numdata == 0, numdata <= r_pempty
//   full, pfull        numdata == DEPTH, numdata >= r_pfull
//   err_clr            clears the sticky error flags
//   wr_ovf, rd_udf     sticky rejected-write / rejected-read flags
module c3lib_sync_fifo
  import c3lib_fifo_pkg::*;
#(
  parameter int DWIDTH  = 8,
  parameter int AWIDTH  = 4,
  parameter int RD_MODE = FIFO_RD_SHOWAHEAD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [DWIDTH-1:0] wr_data,
  input  logic              rd_en,
  output logic [DWIDTH-1:0] rd_data,
  output logic              rd_valid,
  input  logic [AWIDTH:0]   r_pempty,
  input  logic [AWIDTH:0]   r_pfull,
  output logic [AWIDTH:0]   numdata,
  output logic              empty,
  output logic              pempty,
  output logic              full,
  output logic              pfull,
  input  logic              err_clr,
  output logic              wr_ovf,
  output logic              rd_udf
);

  localparam int              DEPTH   = fifo_depth(AWIDTH);
  localparam logic [AWIDTH:0] DEPTH_C = (AWIDTH+1)'(DEPTH);

  logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [AWIDTH:0]   numdata_q, numdata_d;
  logic              empty_q, empty_d;
  logic              full_q, full_d;
  logic              pempty_q, pempty_d;
  logic              pfull_q, pfull_d;
  logic              wr_ovf_q, wr_ovf_d;
  logic              rd_udf_q, rd_udf_d;

  logic              rd_acc;
  logic              wr_acc;
  logic              mem_we;
  logic [DWIDTH-1:0] mem_rdata;

  always_comb begin
    rd_acc = rd_en & ~empty_q;
    // A write into a full FIFO is still accepted when a read frees a slot
    // in the same cycle.
    wr_acc = wr_en & (~full_q | rd_acc);
    mem_we = wr_acc & ~clr;

    wr_ptr_d  = wr_acc ? wr_ptr_q + AWIDTH'(1) : wr_ptr_q;
    rd_ptr_d  = rd_acc ? rd_ptr_q + AWIDTH'(1) : rd_ptr_q;
    numdata_d = numdata_q + (AWIDTH+1)'(wr_acc) - (AWIDTH+1)'(rd_acc);

    // Flags are registered from next-state occupancy so they line up with
    // numdata without an extra cycle of latency.
    empty_d  = (numdata_d == '0);
    full_d   = (numdata_d == DEPTH_C);
    pempty_d = (numdata_d <= r_pempty);
    pfull_d  = (numdata_d >= r_pfull);

    if (clr) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      numdata_d = '0;
      empty_d   = 1'b1;
      full_d    = 1'b0;
      pempty_d  = 1'b1;
      pfull_d   = 1'b0;
    end

    // A new error in the same cycle as err_clr wins; clr suppresses
    // new errors but does not clear existing ones.
    wr_ovf_d = (wr_en & ~wr_acc & ~clr) | (wr_ovf_q & ~err_clr);
    rd_udf_d = (rd_en & ~rd_acc & ~clr) | (rd_udf_q & ~err_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      numdata_q <= '0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      pempty_q  <= 1'b1;
      pfull_q   <= 1'b0;
      wr_ovf_q  <= 1'b0;
      rd_udf_q  <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      numdata_q <= numdata_d;
      empty_q   <= empty_d;
      full_q    <= full_d;
      pempty_q  <= pempty_d;
      pfull_q   <= pfull_d;
      wr_ovf_q  <= wr_ovf_d;
      rd_udf_q  <= rd_udf_d;
    end
  end

  c3lib_fifo_mem #(
    .DWIDTH (DWIDTH),
    .AWIDTH (AWIDTH)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (mem_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (mem_rdata)
  );

  generate
    if (RD_MODE == FIFO_RD_SHOWAHEAD) begin : g_showahead
      assign rd_data  = mem_rdata;
      assign rd_valid = ~empty_q;
    end else begin : g_regread
      logic [DWIDTH-1:0] rd_data_q, rd_data_d;
      logic              rd_valid_q, rd_valid_d;

      always_comb begin
        rd_valid_d = rd_acc & ~clr;
        rd_data_d  = rd_valid_d ? mem_rdata : rd_data_q;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_data_q  <= '0;
          rd_valid_q <= 1'b0;
        end else begin
          rd_data_q  <= rd_data_d;
          rd_valid_q <= rd_valid_d;
        end
      end

      assign rd_data  = rd_data_q;
      assign rd_valid = rd_valid_q;
    end
  endgenerate

  assign numdata = numdata_q;
  assign empty   = empty_q;
  assign full    = full_q;
  assign pempty  = pempty_q;
  assign pfull   = pfull_q;
  assign wr_ovf  = wr_ovf_q;
  assign rd_udf  = rd_udf_q;

endmodule

// File: tb/tb_c3lib_sync_fifo.sv
// Bench for c3lib_sync_fifo: one show-ahead and one registered-read
// instance (AWIDTH=2, DEPTH=4) share the same stimulus. A queue-based
// model predicts every output and is compared on each falling edge;
// directed steps add literal expectations.
module tb_c3lib_sync_fifo;

  localparam int DW    = 8;
  localparam int AW    = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clr, wr_en, rd_en, err_clr;
  logic [DW-1:0] wr_data;
  logic [AW:0]   r_pempty, r_pfull;

  logic [DW-1:0] sa_rd_data, rg_rd_data;
  logic          sa_rd_valid, rg_rd_valid;
  logic [AW:0]   sa_numdata, rg_numdata;
  logic          sa_empty, sa_pempty, sa_full, sa_pfull, sa_wr_ovf, sa_rd_udf;
  logic          rg_empty, rg_pempty, rg_full, rg_pfull, rg_wr_ovf, rg_rd_udf;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  c3lib_sync_fifo #(.DWIDTH(DW), .AWIDTH(AW), .RD_MODE(0)) u_sa (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(sa_rd_data), .rd_valid(sa_rd_valid),
    .r_pempty(r_pempty), .r_pfull(r_pfull), .numdata(sa_numdata),
    .empty(sa_empty), .pempty(sa_pempty), .full(sa_full), .pfull(sa_pfull),
    .err_clr(err_clr), .wr_ovf(sa_wr_ovf), .rd_udf(sa_rd_udf)
  );

  c3lib_sync_fifo #(.DWIDTH(DW), .AWIDTH(AW), .RD_MODE(1)) u_rg (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(rg_rd_data), .rd_valid(rg_rd_valid),
    .r_pempty(r_pempty), .r_pfull(r_pfull), .numdata(rg_numdata),
    .empty(rg_empty), .pempty(rg_pempty), .full(rg_full), .pfull(rg_pfull),
    .err_clr(err_clr), .wr_ovf(rg_wr_ovf), .rd_udf(rg_rd_udf)
  );

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: contents as a queue, plus the registered-read state.
  logic [DW-1:0] mq[$];
  bit            m_ovf, m_udf, m_rv, m_pfhold;
  logic [DW-1:0] m_rdq;
  int            m_pe_thr, m_pf_thr;
  bit            ra, wa;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_ovf = 0; m_udf = 0; m_rv = 0; m_rdq = '0;
      m_pfhold = 1; m_pe_thr = DEPTH; m_pf_thr = 0;
    end else begin
      ra = 0; wa = 0;
      if (clr) begin
        mq.delete();
        m_rv = 0;
        m_pfhold = 1;
      end else begin
        ra = rd_en && (mq.size() > 0);
        wa = wr_en && ((mq.size() < DEPTH) || ra);
        if (ra) begin m_rdq = mq.pop_front(); m_rv = 1; end
        else m_rv = 0;
        if (wa) mq.push_back(wr_data);
        m_pfhold = 0;
      end
      m_pe_thr = int'(r_pempty);
      m_pf_thr = int'(r_pfull);
      if (err_clr) begin m_ovf = 0; m_udf = 0; end
      if (!clr && wr_en && !wa) m_ovf = 1;
      if (!clr && rd_en && !ra) m_udf = 1;
    end
  end

  // Compare process: every falling edge once checking is enabled.
  always @(negedge clk) begin
    if (chk_en) begin
      int n;
      n = mq.size();
      check("sa.numdata", int'(sa_numdata), n);
      check("rg.numdata", int'(rg_numdata), n);
      check("sa.empty",   int'(sa_empty),  int'(n == 0));
      check("rg.empty",   int'(rg_empty),  int'(n == 0));
      check("sa.full",    int'(sa_full),   int'(n == DEPTH));
      check("rg.full",    int'(rg_full),   int'(n == DEPTH));
      check("sa.pempty",  int'(sa_pempty), int'(n <= m_pe_thr));
      check("rg.pempty",  int'(rg_pempty), int'(n <= m_pe_thr));
      check("sa.pfull",   int'(sa_pfull),  m_pfhold ? 0 : int'(n >= m_pf_thr));
      check("rg.pfull",   int'(rg_pfull),  m_pfhold ? 0 : int'(n >= m_pf_thr));
      check("sa.wr_ovf",  int'(sa_wr_ovf), int'(m_ovf));
      check("rg.wr_ovf",  int'(rg_wr_ovf), int'(m_ovf));
      check("sa.rd_udf",  int'(sa_rd_udf), int'(m_udf));
      check("rg.rd_udf",  int'(rg_rd_udf), int'(m_udf));
      check("sa.rd_valid", int'(sa_rd_valid), int'(n != 0));
      if (n != 0) check("sa.rd_data", int'(sa_rd_data), int'(mq[0]));
      check("rg.rd_valid", int'(rg_rd_valid), int'(m_rv));
      check("rg.rd_data",  int'(rg_rd_data),  int'(m_rdq));
    end
  end

  task automatic cyc(input logic w, input logic [DW-1:0] d, input logic r,
                     input logic c, input logic ec);
    wr_en = w; wr_data = d; rd_en = r; clr = c; err_clr = ec;
    @(posedge clk);
    #1;
  endtask

  logic [DW-1:0] drain_exp [4];

  initial begin
    rst_n = 1'b0; clr = 0; wr_en = 0; rd_en = 0; err_clr = 0; wr_data = '0;
    r_pfull = 3'd3; r_pempty = 3'd1;
    repeat (2) @(posedge clk);
    #1;
    check("rst.numdata",  int'(sa_numdata), 0);
    check("rst.empty",    int'(sa_empty), 1);
    check("rst.full",     int'(sa_full), 0);
    check("rst.pempty",   int'(sa_pempty), 1);
    check("rst.pfull",    int'(rg_pfull), 0);
    check("rst.sa_data",  int'(sa_rd_data), 0);
    check("rst.rg_valid", int'(rg_rd_valid), 0);
    check("rst.ovf_udf",  int'({sa_wr_ovf, sa_rd_udf}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_en = 1'b1;

    // Fill with A1..A4; thresholds pfull=3, pempty=1
    cyc(1, 8'hA1, 0, 0, 0);
    check("t1.num1",  int'(sa_numdata), 1);
    check("t1.head",  int'(sa_rd_data), 'hA1);
    check("t1.empty", int'(sa_empty), 0);
    check("t1.pe1",   int'(sa_pempty), 1);
    cyc(1, 8'hA2, 0, 0, 0);
    check("t1.num2",  int'(sa_numdata), 2);
    check("t1.pe2",   int'(sa_pempty), 0);
    check("t1.pf2",   int'(sa_pfull), 0);
    cyc(1, 8'hA3, 0, 0, 0);
    check("t1.pf3",   int'(sa_pfull), 1);
    cyc(1, 8'hA4, 0, 0, 0);
    check("t1.num4",  int'(sa_numdata), 4);
    check("t1.full",  int'(sa_full), 1);

    // Overflow, stickiness, err_clr
    cyc(1, 8'hFF, 0, 0, 0);
    check("t2.num",   int'(sa_numdata), 4);
    check("t2.ovf",   int'(sa_wr_ovf), 1);
    cyc(0, 8'h00, 0, 0, 0);
    check("t2.ovf_sticky", int'(rg_wr_ovf), 1);
    cyc(0, 8'h00, 0, 0, 1);
    check("t2.ovf_clr", int'(sa_wr_ovf), 0);

    // Simultaneous read+write at full
    cyc(1, 8'hB5, 1, 0, 0);
    check("t3.num",   int'(sa_numdata), 4);
    check("t3.head",  int'(sa_rd_data), 'hA2);
    check("t3.rgdat", int'(rg_rd_data), 'hA1);
    drain_exp[0] = 8'hA2; drain_exp[1] = 8'hA3;
    drain_exp[2] = 8'hA4; drain_exp[3] = 8'hB5;
    for (int i = 0; i < 4; i++) begin
      cyc(0, 8'h00, 1, 0, 0);
      check("t3.drain", int'(rg_rd_data), int'(drain_exp[i]));
    end
    check("t3.empty", int'(sa_empty), 1);

    // Empty with read+write: write accepted, read rejected
    cyc(1, 8'h11, 1, 0, 0);
    check("t4.udf",   int'(sa_rd_udf), 1);
    check("t4.num",   int'(sa_numdata), 1);
    check("t4.head",  int'(sa_rd_data), 'h11);
    check("t4.rgv",   int'(rg_rd_valid), 0);

    // Registered read timing
    cyc(0, 8'h00, 1, 0, 0);
    check("t5.v11",   int'(rg_rd_valid), 1);
    check("t5.d11",   int'(rg_rd_data), 'h11);
    cyc(1, 8'h5A, 0, 0, 0);
    check("t5.vlow",  int'(rg_rd_valid), 0);
    cyc(0, 8'h00, 1, 0, 0);
    check("t5.v5a",   int'(rg_rd_valid), 1);
    check("t5.d5a",   int'(rg_rd_data), 'h5A);
    cyc(0, 8'h00, 0, 0, 0);
    check("t5.vdrop", int'(rg_rd_valid), 0);
    check("t5.hold",  int'(rg_rd_data), 'h5A);

    // Thresholds and flush
    cyc(1, 8'hC1, 0, 0, 0);
    cyc(1, 8'hC2, 0, 0, 0);
    check("t6.pe2",   int'(rg_pempty), 0);
    cyc(1, 8'hC3, 0, 0, 0);
    check("t6.pf3",   int'(rg_pfull), 1);
    cyc(1, 8'hC4, 0, 0, 0);
    cyc(1, 8'hEE, 0, 0, 0);
    check("t6.ovf",   int'(sa_wr_ovf), 1);
    cyc(1, 8'h77, 1, 1, 0);
    check("t6.num",   int'(sa_numdata), 0);
    check("t6.empty", int'(sa_empty), 1);
    check("t6.pe",    int'(sa_pempty), 1);
    check("t6.pf",    int'(sa_pfull), 0);
    check("t6.ovf_kept", int'(sa_wr_ovf), 1);
    check("t6.rgv",   int'(rg_rd_valid), 0);
    check("t6.rghold", int'(rg_rd_data), 'h5A);

    // Boundary thresholds: r_pfull=0 forces pfull, r_pempty=DEPTH forces pempty
    r_pfull = 3'd0; r_pempty = 3'd4;
    cyc(0, 8'h00, 0, 0, 0);
    check("t7.pf0",   int'(sa_pfull), 1);
    for (int i = 0; i < 4; i++) cyc(1, 8'hD0 + 8'(i), 0, 0, 0);
    check("t7.pe_full", int'(sa_pempty), 1);
    check("t7.full",  int'(sa_full), 1);
    cyc(1, 8'hEF, 0, 0, 1);
    check("t7.setwins", int'(sa_wr_ovf), 1);
    check("t7.udfclr",  int'(sa_rd_udf), 0);
    cyc(0, 8'h00, 0, 0, 1);
    check("t7.ovfclr",  int'(sa_wr_ovf), 0);

    // Mixed traffic
    r_pfull = 3'd3; r_pempty = 3'd1;
    for (int i = 0; i < 60; i++) begin
      cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 9) == 0));
    end

    // Asynchronous reset mid-operation
    cyc(0, 8'h00, 0, 1, 0);
    cyc(0, 8'h00, 1, 0, 0);
    check("t8.udf",   int'(sa_rd_udf), 1);
    cyc(1, 8'h21, 0, 0, 0);
    cyc(1, 8'h22, 0, 0, 0);
    cyc(0, 8'h00, 1, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t8.num",   int'(sa_numdata), 0);
    check("t8.empty", int'(rg_empty), 1);
    check("t8.pf",    int'(sa_pfull), 0);
    check("t8.udf0",  int'(sa_rd_udf), 0);
    check("t8.sadat", int'(sa_rd_data), 0);
    check("t8.rgdat", int'(rg_rd_data), 0);
    check("t8.rgv",   int'(rg_rd_valid), 0);
    wr_en = 0; rd_en = 0; clr = 0; err_clr = 0;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
